// File: rtl/rob_pkg.sv
// rob_pkg: opcode constants and the reorder-buffer entry layout
package rob_pkg;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        reg_write;
    logic [4:0]  rd_s;
    logic [31:0] value;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;
endpackage

// File: rtl/rob.sv
// rob: circular reorder buffer with in-order commit, flush and operand forwarding
module rob
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = 4,
  localparam int IDX = $clog2(ROB_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           issue_valid,
  output logic           issue_ready,
  input  logic [6:0]     issue_opcode,
  input  logic [4:0]     issue_rd_s,
  output logic [IDX-1:0] issue_rob,
  input  logic           cdb_valid,
  input  logic [IDX-1:0] cdb_rob,
  input  logic [31:0]    cdb_rd_v,
  input  logic           cdb_mispredict,
  input  logic [31:0]    cdb_target,
  input  logic [IDX-1:0] rs1_rob,
  input  logic [IDX-1:0] rs2_rob,
  output logic           rs1_rob_ready,
  output logic           rs2_rob_ready,
  output logic [31:0]    rs1_rob_v,
  output logic [31:0]    rs2_rob_v,
  output logic           commit_reg_write,
  output logic [4:0]     commit_rd_s,
  output logic [31:0]    commit_rd_v,
  output logic [IDX-1:0] commit_rob,
  output logic           flush,
  output logic [31:0]    flush_pc
);
  rob_entry_t     ents [ROB_DEPTH];
  logic [IDX:0]   head, tail;
  logic [IDX-1:0] hi, ti;
  rob_entry_t     he;
  logic           full, empty, head_go, hit1, hit2;
  assign hi    = head[IDX-1:0];
  assign ti    = tail[IDX-1:0];
  assign he    = ents[hi];
  assign empty = head == tail;
  assign full  = (hi == ti) && (head[IDX] != tail[IDX]);
  assign head_go     = !empty && he.valid && he.ready;
  assign issue_ready = !full && !flush;
  assign issue_rob   = ti;
  assign commit_reg_write = head_go && he.reg_write;
  assign commit_rd_s      = head_go ? he.rd_s : '0;
  assign commit_rd_v      = head_go ? he.value : '0;
  assign commit_rob       = hi;
  assign flush            = head_go && he.mispredict;
  assign flush_pc         = flush ? he.target : '0;
  // A result on the CDB this cycle is forwarded ahead of the stored value
  assign hit1 = cdb_valid && cdb_rob == rs1_rob && ents[rs1_rob].valid;
  assign hit2 = cdb_valid && cdb_rob == rs2_rob && ents[rs2_rob].valid;
  assign rs1_rob_ready = hit1 || (ents[rs1_rob].valid && ents[rs1_rob].ready);
  assign rs2_rob_ready = hit2 || (ents[rs2_rob].valid && ents[rs2_rob].ready);
  assign rs1_rob_v = hit1 ? cdb_rd_v : rs1_rob_ready ? ents[rs1_rob].value : '0;
  assign rs2_rob_v = hit2 ? cdb_rd_v : rs2_rob_ready ? ents[rs2_rob].value : '0;
  // Allocate at tail, capture CDB results, retire head; flush wipes everything
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) ents[i] <= '0;
    end else begin
      if (issue_valid && issue_ready) begin
        ents[ti].valid      <= 1'b1;
        ents[ti].ready      <= 1'b0;
        ents[ti].reg_write  <= issue_rd_s != '0 && issue_opcode != OP_BR && issue_opcode != OP_STORE;
        ents[ti].rd_s       <= issue_rd_s;
        ents[ti].mispredict <= 1'b0;
        tail                <= tail + 1'b1;
      end
      if (cdb_valid && ents[cdb_rob].valid) begin
        ents[cdb_rob].ready      <= 1'b1;
        ents[cdb_rob].value      <= cdb_rd_v;
        ents[cdb_rob].mispredict <= cdb_mispredict;
        ents[cdb_rob].target     <= cdb_target;
      end
      if (head_go) begin
        ents[hi].valid <= 1'b0;
        head           <= head + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed stimulus with a commit scoreboard for the reorder buffer
module tb_rob;
  localparam logic [6:0] ALU = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ST  = 7'b0100011;
  typedef struct packed {
    logic [1:0]  rob;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] v;
    logic        fl;
    logic [31:0] pc;
  } cm_t;
  logic clk = 0, rst = 1;
  logic issue_valid = 0, issue_ready;
  logic [6:0] issue_opcode = '0;
  logic [4:0] issue_rd_s = '0;
  logic [1:0] issue_rob;
  logic cdb_valid = 0, cdb_mispredict = 0;
  logic [1:0] cdb_rob = '0, rs1_rob = '0, rs2_rob = '0;
  logic [31:0] cdb_rd_v = '0, cdb_target = '0;
  logic rs1_rob_ready, rs2_rob_ready;
  logic [31:0] rs1_rob_v, rs2_rob_v;
  logic commit_reg_write, flush;
  logic [4:0] commit_rd_s;
  logic [31:0] commit_rd_v, flush_pc;
  logic [1:0] commit_rob;
  int n_chk = 0, n_fail = 0;
  cm_t q[$];
  rob #(.ROB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
    .issue_rd_s(issue_rd_s), .issue_rob(issue_rob),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rs1_rob(rs1_rob), .rs2_rob(rs2_rob),
    .rs1_rob_ready(rs1_rob_ready), .rs2_rob_ready(rs2_rob_ready),
    .rs1_rob_v(rs1_rob_v), .rs2_rob_v(rs2_rob_v),
    .commit_reg_write(commit_reg_write), .commit_rd_s(commit_rd_s),
    .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
    .flush(flush), .flush_pc(flush_pc)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(logic [6:0] op, logic [4:0] rd);
    issue_valid = 1;
    issue_opcode = op;
    issue_rd_s = rd;
    tick();
    issue_valid = 0;
  endtask
  task automatic cdb(logic [1:0] r, logic [31:0] v, logic mp, logic [31:0] tg);
    cdb_valid = 1;
    cdb_rob = r;
    cdb_rd_v = v;
    cdb_mispredict = mp;
    cdb_target = tg;
    tick();
    cdb_valid = 0;
    cdb_mispredict = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  // Every commit the DUT presents must match the oldest expected commit
  always @(negedge clk) begin
    if (!rst && (commit_reg_write || flush || commit_rd_s != 0 || commit_rd_v != 0)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got rob %0d rd %0d v %h flush %0b, expected none",
                 commit_rob, commit_rd_s, commit_rd_v, flush);
      end else begin
        cm_t e, a;
        e = q.pop_front();
        a = '{commit_rob, commit_reg_write, commit_rd_s, commit_rd_v, flush, flush_pc};
        if (a !== e) begin
          n_fail++;
          $display("FAIL commit_rec: got %h expected %h", a, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    do_reset();
    chk("rst_ready", issue_ready, 1);
    chk("rst_rob", issue_rob, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_crw", commit_reg_write, 0);
    chk("rst_rs1_ready", rs1_rob_ready, 0);
    chk("rst_rs1_v", rs1_rob_v, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fill_rob", issue_rob, i);
      issue(ALU, 5'(i + 1));
    end
    chk("full_ready", issue_ready, 0);
    issue(ALU, 5'd9);
    chk("full_tail", issue_rob, 0);
    chk("full_ready2", issue_ready, 0);
    q.push_back('{2'd0, 1'b1, 5'd1, 32'hAA, 1'b0, 32'h0});
    q.push_back('{2'd1, 1'b1, 5'd2, 32'h11, 1'b0, 32'h0});
    q.push_back('{2'd2, 1'b1, 5'd3, 32'h22, 1'b0, 32'h0});
    q.push_back('{2'd3, 1'b1, 5'd4, 32'h44, 1'b0, 32'h0});
    cdb(2'd2, 32'h22, 0, 0);
    cdb(2'd0, 32'hAA, 0, 0);
    cdb(2'd1, 32'h11, 0, 0);
    cdb(2'd3, 32'h44, 0, 0);
    tick();
    tick();
    chk("drain_q", q.size(), 0);
    chk("drain_ready", issue_ready, 1);
    issue(BR, 5'd5);
    issue(ST, 5'd6);
    issue(ALU, 5'd0);
    q.push_back('{2'd0, 1'b0, 5'd5, 32'h1, 1'b0, 32'h0});
    q.push_back('{2'd1, 1'b0, 5'd6, 32'h2, 1'b0, 32'h0});
    q.push_back('{2'd2, 1'b0, 5'd0, 32'h3, 1'b0, 32'h0});
    cdb(2'd0, 32'h1, 0, 0);
    cdb(2'd1, 32'h2, 0, 0);
    cdb(2'd2, 32'h3, 0, 0);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) issue(ALU, 5'(i + 7));
    q.push_back('{2'd0, 1'b1, 5'd7, 32'h30, 1'b0, 32'h0});
    q.push_back('{2'd1, 1'b1, 5'd8, 32'h31, 1'b1, 32'h1000_0040});
    cdb(2'd3, 32'h33, 0, 0);
    cdb(2'd2, 32'h32, 0, 0);
    cdb(2'd1, 32'h31, 1, 32'h1000_0040);
    cdb(2'd0, 32'h30, 0, 0);
    chk("pre_flush", flush, 0);
    tick();
    chk("flush", flush, 1);
    chk("flush_pc", flush_pc, 32'h1000_0040);
    chk("flush_ready", issue_ready, 0);
    tick();
    chk("post_flush_rob", issue_rob, 0);
    chk("post_flush_ready", issue_ready, 1);
    chk("post_flush_flag", flush, 0);
    chk("post_flush_pc", flush_pc, 0);
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("pair_rob", issue_rob, k % 4);
      issue(ALU, 5'(k + 1));
      q.push_back('{2'(k % 4), 1'b1, 5'(k + 1), 32'h100 + k, 1'b0, 32'h0});
      cdb(2'(k % 4), 32'h100 + k, 0, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) issue(ALU, 5'(i + 11));
    chk("full2_ready", issue_ready, 0);
    q.push_back('{2'd2, 1'b1, 5'd11, 32'h200, 1'b0, 32'h0});
    cdb(2'd2, 32'h200, 0, 0);
    issue_valid = 1;
    issue_opcode = ALU;
    issue_rd_s = 5'd15;
    chk("nocredit_ready", issue_ready, 0);
    tick();
    chk("credit_ready", issue_ready, 1);
    chk("credit_rob", issue_rob, 2);
    tick();
    issue_valid = 0;
    chk("credit_accept_rob", issue_rob, 3);
    chk("credit_full", issue_ready, 0);
    do_reset();
    chk("midrst_ready", issue_ready, 1);
    chk("midrst_rob", issue_rob, 0);
    issue(ALU, 5'd1);
    issue(ALU, 5'd2);
    rs1_rob = 2'd1;
    rs2_rob = 2'd3;
    cdb_valid = 1;
    cdb_rob = 2'd1;
    cdb_rd_v = 32'hDEADBEEF;
    #1;
    chk("fwd_ready", rs1_rob_ready, 1);
    chk("fwd_v", rs1_rob_v, 32'hDEADBEEF);
    chk("rs2_invalid_ready", rs2_rob_ready, 0);
    tick();
    cdb_valid = 0;
    #1;
    chk("stored_ready", rs1_rob_ready, 1);
    chk("stored_v", rs1_rob_v, 32'hDEADBEEF);
    cdb_valid = 1;
    cdb_rob = 2'd3;
    cdb_rd_v = 32'h77;
    #1;
    chk("cdb_invalid_fwd", rs2_rob_ready, 0);
    chk("cdb_invalid_v", rs2_rob_v, 0);
    tick();
    cdb_valid = 0;
    #1;
    chk("cdb_invalid_ignored", rs2_rob_ready, 0);
    rs1_rob = 2'd0;
    #1;
    chk("not_ready_v", rs1_rob_v, 0);
    tick();
    chk("final_q", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
